// File: rtl/store_queue_unit.sv
// ---------------------------------------------------------------------------
// store_queue_unit
//
// Store path between the execute stage and data memory. Each accepted store
// is formatted onto byte lanes with matching byte strobes, buffered in a
// DEPTH-entry FIFO, and drained to memory over a valid/ready port. This lets
// the core keep issuing stores while memory is stalling writes.
//
// Parameters
//   XLEN   data/address width, 32 or 64
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset, empties the queue
//   req_valid      store request present
//   req_ready      queue can take a request (count < DEPTH)
//   req_addr       store byte address
//   req_data       rs2 value, operand in the LSBs
//   store_control  00 SB, 01 SH, 10 SW, 11 SD (SD legal only when XLEN=64)
//   mem_valid      head entry valid
//   mem_ready      memory takes the head entry this edge
//   mem_addr       head address with the byte-offset bits cleared
//   mem_wdata      head write data, operand replicated across lanes
//   mem_wstrb      head byte enables
//   store_err      one-cycle pulse after an accepted request was dropped
//   count          number of occupied entries
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned SH/SW/SD requests are accepted
//                     but dropped with a store_err pulse. When undefined they
//                     are silently force-aligned to their access size.
// ---------------------------------------------------------------------------
module store_queue_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_data,
  input  logic [1:0]              store_control,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [XLEN/8-1:0]       mem_wstrb,
  output logic                    store_err,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // FIFO storage, deliberately not reset: only entries between the pointers
  // are ever observed.
  logic [XLEN-1:0]   r_qAddr [DEPTH];
  logic [XLEN-1:0]   r_qData [DEPTH];
  logic [STRB_W-1:0] r_qStrb [DEPTH];

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  // Registered copy of the head entry driving the memory port.
  logic [XLEN-1:0]   r_headAddr;
  logic [XLEN-1:0]   r_headData;
  logic [STRB_W-1:0] r_headStrb;

  logic [OFF_W-1:0]  w_off;
  logic [XLEN-1:0]   w_alignAddr;
  logic [XLEN-1:0]   w_fmtData;
  logic [STRB_W-1:0] w_fmtStrb;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_accept;
  logic              w_drop;
  logic              w_enq;
  logic              w_deq;
  logic [PTR_W-1:0]  w_wrNxt;
  logic [PTR_W-1:0]  w_rdNxt;
  logic [CNT_W-1:0]  w_cntNxt;

  assign w_off       = req_addr[OFF_W-1:0];
  assign w_alignAddr = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  // Lane formatting. Masking the offset with the access size aligns the
  // strobe pattern; on XLEN=32 the word mask clears every offset bit.
  always_comb begin
    w_fmtData = '0;
    w_fmtStrb = '0;
    w_illegal = 1'b0;
    case (store_control)
      2'b00: begin
        w_fmtData = {STRB_W{req_data[7:0]}};
        w_fmtStrb = STRB_W'(1) << w_off;
      end
      2'b01: begin
        w_fmtData = {(XLEN/16){req_data[15:0]}};
        w_fmtStrb = STRB_W'(3) << (w_off & ~OFF_W'(1));
      end
      2'b10: begin
        w_fmtData = {(XLEN/32){req_data[31:0]}};
        w_fmtStrb = STRB_W'(15) << (w_off & ~OFF_W'(3));
      end
      default: begin
        w_fmtData = req_data;
        w_fmtStrb = '1;
        w_illegal = (XLEN == 32);
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Any offset bit below the access size makes the request misaligned.
  always_comb begin
    w_misalign = 1'b0;
    case (store_control)
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = ((w_off & OFF_W'(3)) != '0);
      2'b11:   w_misalign = (w_off != '0);
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // req_ready looks only at the registered count, so a dequeue while full
  // frees the slot one cycle later rather than through a mem_ready path.
  assign req_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_drop    = w_illegal || w_misalign;
  assign w_enq     = w_accept && !w_drop;
  assign w_deq     = (r_count != '0) && mem_ready;

  assign w_wrNxt   = w_enq ? r_wrPtr + PTR_W'(1) : r_wrPtr;
  assign w_rdNxt   = w_deq ? r_rdPtr + PTR_W'(1) : r_rdPtr;

  always_comb begin
    w_cntNxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_cntNxt = r_count + CNT_W'(1);
      2'b01:   w_cntNxt = r_count - CNT_W'(1);
      default: w_cntNxt = r_count;
    endcase
  end

  // Entry write; the full check in req_ready keeps this from overwriting
  // a live entry.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_qAddr[r_wrPtr] <= w_alignAddr;
      r_qData[r_wrPtr] <= w_fmtData;
      r_qStrb[r_wrPtr] <= w_fmtStrb;
    end
  end

  // Pointers, occupancy and the drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wrPtr <= w_wrNxt;
      r_rdPtr <= w_rdNxt;
      r_count <= w_cntNxt;
      r_err   <= w_accept && w_drop;
    end
  end

  // Head register tracks the entry at the next read pointer. When the queue
  // is about to be empty apart from the store being written this edge, that
  // store bypasses the array so it appears on mem_* one edge after accept.
  // With no dequeue the selected entry is unchanged, which keeps mem_* stable
  // during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_headAddr <= '0;
      r_headData <= '0;
      r_headStrb <= '0;
    end else if (w_cntNxt != '0) begin
      if (w_enq && (r_wrPtr == w_rdNxt)) begin
        r_headAddr <= w_alignAddr;
        r_headData <= w_fmtData;
        r_headStrb <= w_fmtStrb;
      end else begin
        r_headAddr <= r_qAddr[w_rdNxt];
        r_headData <= r_qData[w_rdNxt];
        r_headStrb <= r_qStrb[w_rdNxt];
      end
    end
  end

  assign mem_valid = (r_count != '0);
  assign mem_addr  = r_headAddr;
  assign mem_wdata = r_headData;
  assign mem_wstrb = r_headStrb;
  assign store_err = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_store_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_store_queue_unit
//
// Directed bench for store_queue_unit (XLEN=32, DEPTH=4). A queue-based
// model predicts occupancy, the head entry and the drop pulse from the
// store rules. A negedge process compares the DUT against it on every cycle.
// Hand-computed literals pin the key cases.
// ---------------------------------------------------------------------------
module tb_store_queue_unit;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int STRB_W = XLEN / 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_data;
  logic [1:0]        store_control;
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              store_err;
  logic [$clog2(DEPTH):0] count;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [STRB_W-1:0] strb;
  } entry_t;

  entry_t modelQ[$];
  logic   mErr;

  store_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .store_control (store_control),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .store_err     (store_err),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected memory entry from the lane rules: an access of size bytes covers
  // the size-aligned group holding the offset, and every lane carries the
  // operand byte at its position within that group.
  function automatic entry_t formatStore(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] data,
                                         input logic [1:0] ctl);
    entry_t e;
    int size = 1 << ctl;
    int off  = int'(addr % STRB_W);
    int base = off - (off % size);
    e.addr = addr - XLEN'(off);
    e.data = '0;
    e.strb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      e.data[8*i +: 8] = data[8*(i % size) +: 8];
      e.strb[i]        = (i >= base) && (i < base + size);
    end
    return e;
  endfunction

  function automatic bit isDropped(input logic [XLEN-1:0] addr, input logic [1:0] ctl);
    bit res = (ctl == 2'b11) && (XLEN == 32);
`ifdef MISALIGN_TRAP_EN
    if ((addr % (1 << ctl)) != 0) res = 1'b1;
`else
    if (addr[0] === 1'bx) res = 1'b1;
`endif
    return res;
  endfunction

  // Behavioural model: one handshake decision per rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      mErr <= 1'b0;
    end else begin : modelStep
      automatic int sizeBefore = modelQ.size();
      automatic bit accepted = req_valid && (sizeBefore < DEPTH);
      automatic bit dropped  = accepted && isDropped(req_addr, store_control);
      mErr <= dropped;
      if (sizeBefore != 0 && mem_ready) void'(modelQ.pop_front());
      if (accepted && !dropped) modelQ.push_back(formatStore(req_addr, req_data, store_control));
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cmp_count", 64'(count), 64'(modelQ.size()));
      checkOutput("cmp_req_ready", 64'(req_ready), 64'(modelQ.size() < DEPTH));
      checkOutput("cmp_mem_valid", 64'(mem_valid), 64'(modelQ.size() != 0));
      checkOutput("cmp_store_err", 64'(store_err), 64'(mErr));
      if (modelQ.size() != 0) begin
        checkOutput("cmp_mem_addr", 64'(mem_addr), 64'(modelQ[0].addr));
        checkOutput("cmp_mem_wdata", 64'(mem_wdata), 64'(modelQ[0].data));
        checkOutput("cmp_mem_wstrb", 64'(mem_wstrb), 64'(modelQ[0].strb));
      end
    end
  end

  // Present one request and hold it until it is taken; returns 1 time unit
  // after the accepting edge.
  task automatic applyStimulus(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                               input logic [1:0] ctl);
    bit taken = 1'b0;
    req_addr      = addr;
    req_data      = data;
    store_control = ctl;
    req_valid     = 1'b1;
    for (int c = 0; c < 20 && !taken; c++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!taken) checkOutput("accept_timeout", 64'(req_ready), 64'(1));
  endtask

  task automatic waitEmpty();
    for (int c = 0; c < 30 && count != 0; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 64'(count), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_data      = '0;
    store_control = 2'b00;
    mem_ready     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("rst_store_err", 64'(store_err), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    checkOutput("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
    checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // SB at offset 3, visible one edge after accept
    applyStimulus(32'h0000_1003, 32'hDEAD_BEEF, 2'b00);
    checkOutput("sb_mem_valid", 64'(mem_valid), 64'(1));
    checkOutput("sb_mem_addr", 64'(mem_addr), 64'h1000);
    checkOutput("sb_mem_wdata", 64'(mem_wdata), 64'hEFEF_EFEF);
    checkOutput("sb_mem_wstrb", 64'(mem_wstrb), 64'b1000);
    mem_ready = 1'b1;
    waitEmpty();
    mem_ready = 1'b0;

    // SH upper half
    applyStimulus(32'h0000_2002, 32'h0000_ABCD, 2'b01);
    checkOutput("sh_mem_wdata", 64'(mem_wdata), 64'hABCD_ABCD);
    checkOutput("sh_mem_wstrb", 64'(mem_wstrb), 64'b1100);
    mem_ready = 1'b1;
    waitEmpty();
    mem_ready = 1'b0;

    // SW aligned
    applyStimulus(32'h0000_3000, 32'h1234_5678, 2'b10);
    checkOutput("sw_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
    checkOutput("sw_mem_wstrb", 64'(mem_wstrb), 64'hF);
    mem_ready = 1'b1;
    waitEmpty();
    mem_ready = 1'b0;

    // Fill to DEPTH with memory stalled, hold a fifth, then drain in order
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'h100 + 32'(4*i), 32'hA0 + 32'(i), 2'b10);
    checkOutput("full_count", 64'(count), 64'(4));
    checkOutput("full_req_ready", 64'(req_ready), 64'(0));
    req_addr      = 32'h200;
    req_data      = 32'hB5;
    store_control = 2'b10;
    req_valid     = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_count", 64'(count), 64'(4));
    checkOutput("stall_mem_addr", 64'(mem_addr), 64'h100);
    checkOutput("stall_mem_wdata", 64'(mem_wdata), 64'hA0);
    mem_ready = 1'b1;
    applyStimulus(32'h200, 32'hB5, 2'b10);
    waitEmpty();
    mem_ready = 1'b0;

    // Occupancy 2 with simultaneous accept and drain across pointer wrap
    applyStimulus(32'h600, 32'hC0, 2'b10);
    applyStimulus(32'h604, 32'hC1, 2'b10);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h608 + 32'(4*k), 32'hC2 + 32'(k), 2'b10);
      checkOutput("simul_count", 64'(count), 64'(2));
    end
    waitEmpty();
    mem_ready = 1'b0;

    // Misaligned SW
    applyStimulus(32'h0000_4001, 32'hCAFE_F00D, 2'b10);
`ifdef MISALIGN_TRAP_EN
    checkOutput("mis_store_err", 64'(store_err), 64'(1));
    checkOutput("mis_count", 64'(count), 64'(0));
    @(posedge clk);
    #1;
    checkOutput("mis_err_clear", 64'(store_err), 64'(0));
`else
    checkOutput("mis_count", 64'(count), 64'(1));
    checkOutput("mis_mem_addr", 64'(mem_addr), 64'h4000);
    checkOutput("mis_mem_wstrb", 64'(mem_wstrb), 64'hF);
    checkOutput("mis_store_err", 64'(store_err), 64'(0));
`endif
    mem_ready = 1'b1;
    waitEmpty();
    mem_ready = 1'b0;

    // SD is illegal at XLEN=32: accepted, dropped, one-cycle error pulse
    applyStimulus(32'h700, 32'h11, 2'b00);
    applyStimulus(32'h708, 32'h55, 2'b11);
    checkOutput("sd_store_err", 64'(store_err), 64'(1));
    checkOutput("sd_count", 64'(count), 64'(1));
    @(posedge clk);
    #1;
    checkOutput("sd_err_clear", 64'(store_err), 64'(0));
    mem_ready = 1'b1;
    waitEmpty();
    mem_ready = 1'b0;

    // Asynchronous reset mid-stall with three queued stores
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h800 + 32'(4*i), 32'hD0 + 32'(i), 2'b10);
    checkOutput("pre_rst_count", 64'(count), 64'(3));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("async_rst_count", 64'(count), 64'(0));
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_5005, 32'h0000_0077, 2'b00);
    checkOutput("post_rst_mem_addr", 64'(mem_addr), 64'h5004);
    checkOutput("post_rst_mem_wdata", 64'(mem_wdata), 64'h7777_7777);
    checkOutput("post_rst_mem_wstrb", 64'(mem_wstrb), 64'b0010);
    mem_ready = 1'b1;
    waitEmpty();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
